// File: rtl/ram_sdp_param.sv
// rtl/ram_sdp_param.sv - parametrised simple-dual-port RAM with lane mask, clear sequencer and optional output register
// Depth is 2**ADDR_W; the clear sequencer zeroes every word after reset or clr.
module ram_sdp_param #(
   parameter int DATA_W   = 10,
   parameter int ADDR_W   = 10,
   parameter int LANES    = 2,
   parameter int RDW_MODE = 0,
   parameter int OUT_REG  = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   output logic              busy_o,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [LANES-1:0]  wmask_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              rvalid_o
);

   localparam int LW    = DATA_W / LANES;
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cptr_q, cptr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              wr_acc, rd_acc;
   logic [DATA_W-1:0] wr_merged, rd_word;
   logic [DATA_W-1:0] rdata1_q, rdata2_q;
   logic              rvalid1_q, rvalid2_q;

   always_comb begin
      state_d = state_q;
      cptr_d  = cptr_q;
      busy_o  = (state_q == ST_CLEAR);
      case (state_q)
         ST_CLEAR: begin
            cptr_d = cptr_q + ADDR_W'(1);
            if (cptr_q == '1) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (clr_i) begin
               state_d = ST_CLEAR;
               cptr_d  = '0;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   assign wr_acc = we_i & ~busy_o;
   assign rd_acc = re_i & ~busy_o;

   // Write-first collisions return the old word with only the masked lanes replaced.
   always_comb begin
      wr_merged = mem_q[waddr_i];
      for (int i = 0; i < LANES; i++) begin
         if (wmask_i[i]) wr_merged[i*LW +: LW] = wdata_i[i*LW +: LW];
      end
      rd_word = mem_q[raddr_i];
      if ((RDW_MODE == 1) && wr_acc && (waddr_i == raddr_i)) rd_word = wr_merged;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (state_q == ST_CLEAR) begin
            mem_q[cptr_q] <= '0;
         end else if (wr_acc) begin
            for (int i = 0; i < LANES; i++) begin
               if (wmask_i[i]) mem_q[waddr_i][i*LW +: LW] <= wdata_i[i*LW +: LW];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_CLEAR;
         cptr_q    <= '0;
         rvalid1_q <= 1'b0;
         rdata1_q  <= '0;
         rvalid2_q <= 1'b0;
         rdata2_q  <= '0;
      end else begin
         state_q   <= state_d;
         cptr_q    <= cptr_d;
         rvalid1_q <= rd_acc;
         if (rd_acc) rdata1_q <= rd_word;
         rvalid2_q <= rvalid1_q;
         if (rvalid1_q) rdata2_q <= rdata1_q;
      end
   end

   // The second stage keeps draining reads even while a clear is running.
   assign rdata_o  = (OUT_REG != 0) ? rdata2_q : rdata1_q;
   assign rvalid_o = (OUT_REG != 0) ? rvalid2_q : rvalid1_q;

endmodule

// File: tb/tb_ram_sdp_param.sv
// tb/tb_ram_sdp_param.sv - directed bench for ram_sdp_param
// dut0: read-first, no output register; dut1: write-first, output register.
module tb_ram_sdp_param;

   logic       clk = 1'b0;
   logic       rst, clr, we, re;
   logic [9:0] waddr, raddr, wdata;
   logic [1:0] wmask;
   logic       busy0, busy1, rvalid0, rvalid1;
   logic [9:0] rdata0, rdata1;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   ram_sdp_param #(.RDW_MODE(0), .OUT_REG(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .busy_o(busy0),
      .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wmask_i(wmask),
      .re_i(re), .raddr_i(raddr), .rdata_o(rdata0), .rvalid_o(rvalid0));

   ram_sdp_param #(.RDW_MODE(1), .OUT_REG(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .busy_o(busy1),
      .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wmask_i(wmask),
      .re_i(re), .raddr_i(raddr), .rdata_o(rdata1), .rvalid_o(rvalid1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_clear(input string tag);
      int cnt = 0;
      while (busy0 && cnt < 2000) begin
         tick();
         cnt++;
      end
      chk({tag, "_len"}, 32'(cnt), 32'd1024);
      chk({tag, "_busy1"}, 32'(busy1), 32'd0);
   endtask

   task automatic do_write(input logic [9:0] a, input logic [9:0] d, input logic [1:0] m);
      we = 1'b1; waddr = a; wdata = d; wmask = m;
      tick();
      we = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [9:0] a, input logic [9:0] e0,
                          input logic [9:0] e1);
      re = 1'b1; raddr = a;
      tick();
      re = 1'b0; we = 1'b0;
      chk({tag, "_v0"}, 32'(rvalid0), 32'd1);
      chk({tag, "_d0"}, 32'(rdata0), 32'(e0));
      chk({tag, "_v1early"}, 32'(rvalid1), 32'd0);
      tick();
      chk({tag, "_v1"}, 32'(rvalid1), 32'd1);
      chk({tag, "_d1"}, 32'(rdata1), 32'(e1));
      chk({tag, "_v0off"}, 32'(rvalid0), 32'd0);
   endtask

   initial begin
      logic [9:0] ba [3];
      logic [9:0] bd [3];
      int nrv;
      int cnt;

      rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0;
      waddr = '0; raddr = '0; wdata = '0; wmask = '0;
      repeat (3) tick();
      chk("rst_busy0", 32'(busy0), 32'd1);
      chk("rst_busy1", 32'(busy1), 32'd1);
      chk("rst_rvalid0", 32'(rvalid0), 32'd0);
      chk("rst_rvalid1", 32'(rvalid1), 32'd0);
      chk("rst_rdata0", 32'(rdata0), 32'd0);
      chk("rst_rdata1", 32'(rdata1), 32'd0);
      rst = 1'b0;
      wait_clear("init_clear");

      do_read("rd0", 10'd0, 10'h000, 10'h000);
      do_read("rd511", 10'd511, 10'h000, 10'h000);
      do_read("rd1023", 10'd1023, 10'h000, 10'h000);

      do_write(10'd5, 10'h3FF, 2'b11);
      do_write(10'd5, 10'h000, 2'b01);
      do_read("lane", 10'd5, 10'h3E0, 10'h3E0);
      do_write(10'd5, 10'h000, 2'b00);
      do_read("mask0", 10'd5, 10'h3E0, 10'h3E0);

      do_write(10'd7, 10'h155, 2'b11);
      we = 1'b1; waddr = 10'd7; wdata = 10'h2AA; wmask = 2'b11;
      do_read("rdw", 10'd7, 10'h155, 10'h2AA);
      do_read("rdw_after", 10'd7, 10'h2AA, 10'h2AA);

      do_write(10'd1023, 10'h3FF, 2'b11);
      do_write(10'd0, 10'h001, 2'b11);
      ba[0] = 10'd1023; ba[1] = 10'd0;   ba[2] = 10'd1023;
      bd[0] = 10'h3FF;  bd[1] = 10'h001; bd[2] = 10'h3FF;
      re = 1'b1; raddr = ba[0];
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("b2b_v0_%0d", i), 32'(rvalid0), (i <= 2) ? 32'd1 : 32'd0);
         chk($sformatf("b2b_v1_%0d", i), 32'(rvalid1), (i >= 1 && i <= 3) ? 32'd1 : 32'd0);
         if (i <= 2) chk($sformatf("b2b_d0_%0d", i), 32'(rdata0), 32'(bd[i]));
         if (i >= 1 && i <= 3) chk($sformatf("b2b_d1_%0d", i), 32'(rdata1), 32'(bd[i-1]));
         if (i + 1 < 3) raddr = ba[i+1];
         else re = 1'b0;
      end

      do_write(10'd3, 10'h123, 2'b11);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_busy", 32'(busy0), 32'd1);
      nrv = 0;
      cnt = 0;
      while (busy0 && cnt < 2000) begin
         we = 1'b1; waddr = 10'd3; wdata = 10'h0AA; wmask = 2'b11;
         re = 1'b1; raddr = 10'd3;
         tick();
         cnt++;
         if (rvalid0 || rvalid1) nrv++;
      end
      we = 1'b0; re = 1'b0;
      chk("clr_len", 32'(cnt), 32'd1024);
      chk("clr_no_rvalid", 32'(nrv), 32'd0);
      chk("clr_hold0", 32'(rdata0), 32'h3FF);
      chk("clr_hold1", 32'(rdata1), 32'h3FF);
      do_read("clr_rd3", 10'd3, 10'h000, 10'h000);

      do_write(10'd9, 10'h0F0, 2'b11);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (500) tick();
      chk("mid_busy", 32'(busy0), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_clear("rst_mid");

      do_write(10'd5, 10'h2BC, 2'b11);
      re = 1'b1; raddr = 10'd5;
      tick();
      re = 1'b0;
      chk("inflt_v0", 32'(rvalid0), 32'd1);
      chk("inflt_d0", 32'(rdata0), 32'h2BC);
      rst = 1'b1;
      tick();
      chk("inflt_v1_rst", 32'(rvalid1), 32'd0);
      chk("inflt_d0_rst", 32'(rdata0), 32'd0);
      tick();
      chk("inflt_v1_late", 32'(rvalid1), 32'd0);
      rst = 1'b0;
      wait_clear("rst_inflt");
      do_read("final_rd5", 10'd5, 10'h000, 10'h000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ram_sdp_param.md
# ram_sdp_param

Parametrised simple-dual-port synchronous RAM: one write port and one read port on a single clock, with per-lane write masking and selectable read-during-write behaviour. Reset or a `clr` pulse triggers a hardware clear sequencer that zeroes every word. Read data can pass through an optional output register, and each read is qualified by `rvalid`. It replaces the fixed 10x1024 single-port RAM as the general storage primitive for datapath buffers and lookup tables.

## Interface
- `DATA_W`, default 10: word width in bits.
- `ADDR_W`, default 10: address width; depth is fixed at 2**ADDR_W words.
- `LANES`, default 2: number of write-mask lanes. `DATA_W % LANES` must be 0. Lane width is `DATA_W/LANES`, with lane i = bits [(i+1)*LW-1 : i*LW].
- `RDW_MODE`, default 0: read-during-write to the same address. 0 = read-first (old data), 1 = write-first (new data).
- `OUT_REG`, default 0: 1 adds one output pipeline register.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clr` in 1: one-cycle request to re-run the clear sequence.
- `busy` out 1: high while clearing; all requests are ignored.
- `we` in 1: write request.
- `waddr` in ADDR_W: write address.
- `wdata` in DATA_W: write data.
- `wmask` in LANES: per-lane write enable; only lanes with a 1 are written.
- `re` in 1: read request.
- `raddr` in ADDR_W: read address.
- `rdata` out DATA_W: read data.
- `rvalid` out 1: one-cycle strobe marking new `rdata`.

## Operation
- **FSM states:** CLEAR and IDLE.
  - Reset drives: state=CLEAR, clear pointer `cptr`=0, `busy`=1, `rdata`=0, `rvalid`=0, output-register stage=0.
  - CLEAR: each cycle writes all-zero to `mem[cptr]` and increments `cptr`. When `cptr`==2**ADDR_W-1 is written, the next state is IDLE.
  - IDLE: `busy`=0. Reads and writes are serviced.
  - `clr`=1 in IDLE: next state CLEAR with `cptr`=0. A `re`/`we` in that same cycle is still serviced.
  - `clr` in CLEAR: ignored.
- **Reset mid-clear:** restarts from `cptr`=0.
- **Writes:** on an edge with `we`=1 and `busy`=0, for each lane i with `wmask[i]`=1, `mem[waddr]` lane i <= `wdata` lane i. Other lanes are unchanged. `wmask`=0 is a no-op.
- **Reads:** on an edge with `re`=1 and `busy`=0, the array is read at `raddr` (synchronous read).
- **Read and write in the same cycle:** may target different addresses, and both complete.
- **Same-address collision:** if `raddr`==`waddr` with both requests accepted:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the merged word: masked lanes take `wdata`, unmasked lanes keep the old value.
- **Requests while `busy`=1:** dropped silently. No write, no `rvalid`.
- **`rdata` hold:** `rdata` holds its last value until the next accepted read. It is not cleared by `clr`.
- **Addresses:** all are ADDR_W wide. No wrap or out-of-range case exists; address 2**ADDR_W-1 is a normal word.

## Timing
- **Clear duration:** the first rising edge with `rst`=0 writes word 0. `busy` falls after exactly 2**ADDR_W such edges (1024 with defaults). The same holds for `clr`, counted from the edge that samples `clr`=1.
- **Read latency, OUT_REG=0:** read accepted at edge N gives `rdata` and `rvalid`=1 valid after edge N (one cycle).
- **Read latency, OUT_REG=1:** data and `rvalid` appear after edge N+1 (two cycles).
- **Throughput:** full; back-to-back reads give back-to-back `rvalid`.
- **Write visibility:** a write at edge N is visible to a read accepted at edge N+1 in both modes. Same-edge visibility is set by RDW_MODE.
- **Reset during an in-flight read:** `rvalid` is forced to 0 and the pending pipeline stage is discarded.
- **`busy` while the clear sequence is running:** the pipeline continues to drain reads that were accepted before `busy` rose.

## Test plan
- **Reset clear:** after `rst`, hold idle. `busy` must stay 1 for 1024 cycles, then 0. Reads of addresses 0, 511 and 1023 must return 0 with `rvalid` one cycle after `re`.
- **Lane mask:**
  - Write 0x3FF to addr 5 with `wmask`=2'b11, then 0x000 with `wmask`=2'b01. A read of addr 5 must return 0x3E0.
  - A write with `wmask`=2'b00 must leave the word unchanged.
- **Read-during-write:** preload addr 7 = 0x155, then `we`+`re` at addr 7 with `wdata`=0x2AA and `wmask`=2'b11.
  - RDW_MODE=0 must return 0x155; RDW_MODE=1 must return 0x2AA.
  - A following read must return 0x2AA in both modes.
- **Boundary and back-to-back:** write 0x3FF to addr 1023 and 0x001 to addr 0. Reads of 1023, 0, 1023 on consecutive cycles must give `rvalid` high for 3 cycles with data 0x3FF, 0x001, 0x3FF. Repeat with OUT_REG=1 and check the added cycle of latency.
- **`clr` and blocking:** write 0x123 to addr 3, then pulse `clr`. During the 1024 busy cycles, issue writes of 0x0AA to addr 3 and reads of addr 3; there must be no `rvalid`. After `busy` falls, a read of addr 3 must return 0.
- **Reset mid-clear:** assert `rst` at clear cycle 500. The clear must restart and `busy` must stay high for a full 1024 cycles after `rst` falls. Assert `rst` while a read is in flight; `rvalid` must not assert.
